// File: rtl/agro_sense_sequencer.sv
// ----------------------------------------------------------------------------
// agro_sense_sequencer
//
// Sequences the agrochip classifier. A prescaled tick samples the raw sensor
// bits and debounces them. Once a sample has been seen unchanged on DEBOUNCE
// consecutive ticks it is driven onto the classifier input (bits_o). After
// SETTLE cycles the classifier result (nbit_final_i) is captured into
// decision_o. A positive decision holds the actuator on for at least MIN_ON
// ticks.
//
// Ports:
//   wb_clk_i          system clock
//   rst_n             asynchronous active-low reset
//   en                run enable; 0 holds the block idle
//   sensor_i          raw sensor bits
//   bits_o            last stable sample, driven to the classifier
//   nbit_final_i      classifier result
//   decision_o        last captured classifier result
//   decision_valid_o  one-cycle pulse when decision_o updates
//   actuator_o        actuator drive (pump/valve)
//   busy_o            high while a sample is settling or being captured
//   evt_cnt_o         (AGRO_EVENT_CNT_EN only) saturating count of actuator
//                     turn-on events; cleared only by rst_n
//
// Optional feature macro: AGRO_EVENT_CNT_EN
// ----------------------------------------------------------------------------
module agro_sense_sequencer #(
  parameter int BITS     = 5,
  parameter int PRESCALE = 1000,
  parameter int DEBOUNCE = 3,
  parameter int SETTLE   = 2,
  parameter int MIN_ON   = 8
) (
  input  logic            wb_clk_i,
  input  logic            rst_n,
  input  logic            en,
  input  logic [BITS-1:0] sensor_i,
  output logic [BITS-1:0] bits_o,
  input  logic            nbit_final_i,
  output logic            decision_o,
  output logic            decision_valid_o,
  output logic            actuator_o,
  output logic            busy_o
`ifdef AGRO_EVENT_CNT_EN
  ,
  output logic [15:0]     evt_cnt_o
`endif
);

  localparam logic [15:0] PS_MAX  = 16'(PRESCALE - 1);
  localparam logic [3:0]  DEB_C   = 4'(DEBOUNCE);
  localparam logic [3:0]  SET_C   = 4'(SETTLE);
  localparam logic [7:0]  MINON_C = 8'(MIN_ON);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_APPLY,
    ST_CAPTURE
  } state_t;

  state_t          state;
  logic [15:0]     presc;
  logic [BITS-1:0] last_smp;
  logic [3:0]      stable_cnt;
  logic [3:0]      stable_nxt;
  logic [3:0]      settle_cnt;
  logic [7:0]      on_cnt;
  logic            tick;
  logic            launch;
  logic            reload;

  assign tick = en && (presc == PS_MAX);

  // Debounce count as it will be after this tick; the launch decision uses
  // the updated value so evaluation happens on the DEBOUNCE-th matching tick.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    stable_nxt = 4'd1;
    if (sensor_i == last_smp) begin
      stable_nxt = (stable_cnt >= DEB_C) ? DEB_C : stable_cnt + 4'd1;
    end
  end

  assign launch = tick && (state == ST_WAIT) && (stable_nxt == DEB_C);
  assign reload = (state == ST_CAPTURE) && nbit_final_i;

  // Prescaler and debounce history. Debounce runs on every tick regardless
  // of the FSM state.
  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers see pre-edge values of each other, independent of block order.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      last_smp   <= '0;
      stable_cnt <= '0;
    end else if (!en) begin
      presc      <= '0;
      stable_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + 16'd1;
      if (tick) begin
        last_smp   <= sensor_i;
        stable_cnt <= stable_nxt;
      end
    end
  end

  // Sequencing FSM with registered outputs.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      settle_cnt       <= '0;
      bits_o           <= '0;
      decision_o       <= 1'b0;
      decision_valid_o <= 1'b0;
      busy_o           <= 1'b0;
    end else if (!en) begin
      // Abandon any evaluation in flight; bits_o and decision_o hold.
      state            <= ST_IDLE;
      decision_valid_o <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      decision_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (launch) begin
            bits_o     <= sensor_i;
            settle_cnt <= SET_C;
            busy_o     <= 1'b1;
            state      <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (settle_cnt <= 4'd1) begin
            state <= ST_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_CAPTURE: begin
          decision_o       <= nbit_final_i;
          decision_valid_o <= 1'b1;
          busy_o           <= 1'b0;
          state            <= ST_WAIT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Minimum-on hold. A positive capture (re)loads the hold, taking priority
  // over a tick decrement in the same cycle; a negative capture never cuts
  // the hold short.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      on_cnt <= '0;
    end else if (!en) begin
      on_cnt <= '0;
    end else if (reload) begin
      on_cnt <= MINON_C;
    end else if (tick && (on_cnt != 8'd0)) begin
      on_cnt <= on_cnt - 8'd1;
    end
  end

  assign actuator_o = (on_cnt != 8'd0);

`ifdef AGRO_EVENT_CNT_EN
  // Counts actuator turn-on events only: a reload while already on is not
  // a new episode. Deliberately unaffected by en.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt_o <= '0;
    end else if (en && reload && (on_cnt == 8'd0) && (evt_cnt_o != 16'hFFFF)) begin
      evt_cnt_o <= evt_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_agro_sense_sequencer.sv
// ----------------------------------------------------------------------------
// Testbench for agro_sense_sequencer (PRESCALE=8, DEBOUNCE=3, SETTLE=2,
// MIN_ON=4). The stimulus process enables the block at a known cycle, so
// every sample tick falls on a hand-computed cycle number. Each expected
// capture (cycle of the decision_valid_o pulse, decision, bits) is pushed
// into a scoreboard queue; a monitor pops and compares on every pulse, and
// flags any pulse nothing was expected for.
// ----------------------------------------------------------------------------
module tb_agro_sense_sequencer;

  localparam int BITS = 5;

  logic            wb_clk_i = 1'b0;
  logic            rst_n;
  logic            en;
  logic [BITS-1:0] sensor_i;
  logic [BITS-1:0] bits_o;
  logic            nbit_final_i;
  logic            decision_o;
  logic            decision_valid_o;
  logic            actuator_o;
  logic            busy_o;
`ifdef AGRO_EVENT_CNT_EN
  logic [15:0]     evt_cnt_o;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0;
  int c1;

  typedef struct {
    int              at_cyc;
    logic            dec;
    logic [BITS-1:0] bits;
  } exp_t;

  exp_t sb[$];

  agro_sense_sequencer #(
    .BITS    (BITS),
    .PRESCALE(8),
    .DEBOUNCE(3),
    .SETTLE  (2),
    .MIN_ON  (4)
  ) dut (
    .wb_clk_i        (wb_clk_i),
    .rst_n           (rst_n),
    .en              (en),
    .sensor_i        (sensor_i),
    .bits_o          (bits_o),
    .nbit_final_i    (nbit_final_i),
    .decision_o      (decision_o),
    .decision_valid_o(decision_valid_o),
    .actuator_o      (actuator_o),
    .busy_o          (busy_o)
`ifdef AGRO_EVENT_CNT_EN
    ,
    .evt_cnt_o       (evt_cnt_o)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Number of rising edges so far; read on falling edges.
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge wb_clk_i);
  endtask

  task automatic push(input int c, input logic d, input logic [BITS-1:0] b);
    exp_t e;
    e.at_cyc = c;
    e.dec    = d;
    e.bits   = b;
    sb.push_back(e);
  endtask

  // Tick j of the first enable window ends at this rising edge.
  function automatic int p(input int j);
    return c0 + 8 + 8 * j;
  endfunction

  // Tick j of the second enable window.
  function automatic int q(input int j);
    return c1 + 8 + 8 * j;
  endfunction

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge wb_clk_i);
      if (decision_valid_o === 1'b1) begin
        if (sb.size() == 0) begin
          check("valid_pulse_expected", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("valid_cycle", 32'(cyc), 32'(e.at_cyc));
          check("decision", 32'(decision_o), 32'(e.dec));
          check("bits_at_decision", 32'(bits_o), 32'(e.bits));
        end
      end
    end
  end

  // Watchdog: the whole run is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic all_high;

    rst_n        = 1'b0;
    en           = 1'b0;
    sensor_i     = 5'b10110;
    nbit_final_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);

    // Reset state.
    check("rst_bits", 32'(bits_o), 32'd0);
    check("rst_decision", 32'(decision_o), 32'd0);
    check("rst_valid", 32'(decision_valid_o), 32'd0);
    check("rst_actuator", 32'(actuator_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
`ifdef AGRO_EVENT_CNT_EN
    check("rst_evt", 32'(evt_cnt_o), 32'd0);
`endif

    rst_n = 1'b1;
    @(negedge wb_clk_i);
    en = 1'b1;
    c0 = cyc;

    // Debounce: constant 10110 launches on the 3rd tick and every tick after.
    // The capture of tick 3 sees nbit_final_i=1, all others 0.
    for (int j = 2; j <= 7; j++) push(p(j) + 3, (j == 3), 5'b10110);

    wait_cyc(p(2) - 1);
    check("bits_before_launch", 32'(bits_o), 32'd0);
    check("busy_before_launch", 32'(busy_o), 32'd0);
    wait_cyc(p(2));
    check("bits_first_launch", 32'(bits_o), 32'b10110);
    check("busy_apply", 32'(busy_o), 32'd1);
    wait_cyc(p(2) + 2);
    check("busy_capture", 32'(busy_o), 32'd1);
    wait_cyc(p(2) + 3);
    check("busy_after_capture", 32'(busy_o), 32'd0);

    // Minimum-on hold: one positive capture, zeros afterwards.
    wait_cyc(p(3));
    nbit_final_i = 1'b1;
    wait_cyc(p(3) + 2);
    check("act_before_capture", 32'(actuator_o), 32'd0);
    all_high = 1'b1;
    for (int c = p(3) + 3; c <= p(3) + 31; c++) begin
      wait_cyc(c);
      if (c == p(3) + 3) nbit_final_i = 1'b0;
      if (actuator_o !== 1'b1) all_high = 1'b0;
    end
    check("act_hold_continuous", 32'(all_high), 32'd1);
    wait_cyc(p(3) + 32);
    check("act_hold_end", 32'(actuator_o), 32'd0);
`ifdef AGRO_EVENT_CNT_EN
    check("evt_after_first", 32'(evt_cnt_o), 32'd1);
`endif

    // Glitch rejection: alternate 00001 / 00011 over ticks 8..17.
    wait_cyc(p(7) + 4);
    sensor_i = 5'b00001;
    for (int k = 1; k <= 9; k++) begin
      wait_cyc(p(7 + k) + 4);
      sensor_i = (k % 2 == 1) ? 5'b00011 : 5'b00001;
    end
    wait_cyc(p(17) + 4);
    check("bits_hold_glitch", 32'(bits_o), 32'b10110);
    check("busy_glitch", 32'(busy_o), 32'd0);
    sensor_i = 5'b01010;

    // Hold restart: positive captures at ticks 20 and 22, then one at 27
    // after the hold has expired.
    for (int j = 20; j <= 27; j++) push(p(j) + 3, (j == 20 || j == 22 || j == 27), 5'b01010);

    wait_cyc(p(19) + 1);
    check("bits_no_launch_tick19", 32'(bits_o), 32'b10110);
    wait_cyc(p(20));
    check("bits_launch_tick20", 32'(bits_o), 32'b01010);
    nbit_final_i = 1'b1;
    all_high = 1'b1;
    for (int c = p(20) + 3; c <= p(26) - 1; c++) begin
      wait_cyc(c);
      if (c == p(20) + 3) nbit_final_i = 1'b0;
      if (c == p(22)) nbit_final_i = 1'b1;
      if (c == p(22) + 3) nbit_final_i = 1'b0;
      if (actuator_o !== 1'b1) all_high = 1'b0;
    end
    check("act_restart_continuous", 32'(all_high), 32'd1);
    wait_cyc(p(26));
    check("act_restart_end", 32'(actuator_o), 32'd0);
`ifdef AGRO_EVENT_CNT_EN
    check("evt_reload_no_incr", 32'(evt_cnt_o), 32'd2);
`endif

    wait_cyc(p(27));
    nbit_final_i = 1'b1;
    wait_cyc(p(27) + 3);
    nbit_final_i = 1'b0;
    check("act_third_episode", 32'(actuator_o), 32'd1);
`ifdef AGRO_EVENT_CNT_EN
    check("evt_three_episodes", 32'(evt_cnt_o), 32'd3);
`endif

    // Mid-operation disable: drop en in APPLY after the tick-28 launch.
    wait_cyc(p(28));
    check("busy_before_disable", 32'(busy_o), 32'd1);
    check("act_before_disable", 32'(actuator_o), 32'd1);
    en = 1'b0;
    wait_cyc(p(28) + 1);
    check("dis_actuator", 32'(actuator_o), 32'd0);
    check("dis_busy", 32'(busy_o), 32'd0);
    check("dis_valid", 32'(decision_valid_o), 32'd0);
    check("dis_bits_hold", 32'(bits_o), 32'b01010);
    check("dis_decision_hold", 32'(decision_o), 32'd1);
    sensor_i = 5'b11100;
    wait_cyc(p(28) + 3);
    en = 1'b1;
    c1 = cyc;

    wait_cyc(q(0));
    push(q(2) + 3, 1'b1, 5'b11100);
    wait_cyc(q(1));
    check("reen_no_launch_tick2", 32'(busy_o), 32'd0);
    check("reen_bits_tick2", 32'(bits_o), 32'b01010);
    wait_cyc(q(2));
    check("reen_launch_tick3", 32'(busy_o), 32'd1);
    check("reen_bits_tick3", 32'(bits_o), 32'b11100);
    nbit_final_i = 1'b1;
    wait_cyc(q(2) + 3);
    nbit_final_i = 1'b0;
    check("reen_actuator", 32'(actuator_o), 32'd1);
`ifdef AGRO_EVENT_CNT_EN
    check("evt_not_cleared_by_en", 32'(evt_cnt_o), 32'd4);
`endif

    // Asynchronous reset between clock edges.
    wait_cyc(q(2) + 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bits", 32'(bits_o), 32'd0);
    check("arst_decision", 32'(decision_o), 32'd0);
    check("arst_valid", 32'(decision_valid_o), 32'd0);
    check("arst_actuator", 32'(actuator_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
`ifdef AGRO_EVENT_CNT_EN
    check("arst_evt", 32'(evt_cnt_o), 32'd0);
`endif
    @(negedge wb_clk_i);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
